// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS main controller (FETCH/DECODE/EXEC/MEM/WB) with a DM req/ack timeout
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  input  logic        i_zero,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_mem_ack,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_src,
  output logic        o_ir_we,
  output logic        o_ext_sign,
  output logic        o_alu_src_b,
  output logic [2:0]  o_alu_op,
  output logic        o_reg_we,
  output logic [1:0]  o_reg_dst,
  output logic [1:0]  o_wd_sel,
  output logic        o_mem_req,
  output logic [3:0]  o_mem_be,
  output logic        o_mem_err,
  output logic        o_illegal,
  output logic        o_instr_done,
  output logic [31:0] o_retired
);
  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_retired;
  logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_sb, w_beq, w_jal;
  logic w_alu, w_store, w_mem, w_legal, w_tmo;
  logic       w_pc_we, w_ir_we, w_alu_src_b, w_reg_we, w_mem_req, w_mem_err, w_illegal, w_done;
  logic [1:0] w_pc_src, w_reg_dst, w_wd_sel;
  logic [2:0] w_alu_op;
  logic [3:0] w_mem_be;
  assign w_rtype = i_opcode == 6'h00;
  assign w_addu  = w_rtype && i_funct == 6'h21;
  assign w_subu  = w_rtype && i_funct == 6'h23;
  assign w_jr    = w_rtype && i_funct == 6'h08;
  assign w_ori   = i_opcode == 6'h0D;
  assign w_lui   = i_opcode == 6'h0F;
  assign w_lw    = i_opcode == 6'h23;
  assign w_sw    = i_opcode == 6'h2B;
  assign w_sb    = i_opcode == 6'h28;
  assign w_beq   = i_opcode == 6'h04;
  assign w_jal   = i_opcode == 6'h03;
  assign w_alu   = w_addu | w_subu | w_ori | w_lui;
  assign w_store = w_sw | w_sb;
  assign w_mem   = w_lw | w_store;
  assign w_legal = w_alu | w_mem | w_beq | w_jal | w_jr;
  // A timeout fires in the MEM cycle that would otherwise be the MEM_TIMEOUT-th one without ack
  assign w_tmo = (MEM_TIMEOUT != 0) && !i_mem_ack && (r_cnt == CW'(MEM_TIMEOUT - 1));
  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_FETCH;
    else            r_state <= w_next;
  end
  // MEM wait counter: counts consecutive MEM cycles, clears whenever MEM is left
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_cnt <= '0;
    else            r_cnt <= (r_state == S_MEM && w_next == S_MEM) ? r_cnt + CW'(1) : '0;
  end
  // Retired-instruction counter, bumps on every completed instruction
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)        r_retired <= '0;
    else if (o_instr_done) r_retired <= r_retired + 32'd1;
  end
  // Next-state and per-state datapath controls
  always_comb begin
    w_next      = r_state;
    w_pc_we     = 1'b0;
    w_pc_src    = 2'd0;
    w_ir_we     = 1'b0;
    w_alu_src_b = 1'b0;
    w_alu_op    = 3'd0;
    w_reg_we    = 1'b0;
    w_reg_dst   = 2'd0;
    w_wd_sel    = 2'd0;
    w_mem_req   = 1'b0;
    w_mem_be    = 4'd0;
    w_mem_err   = 1'b0;
    w_illegal   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_we = 1'b1;
        w_pc_we = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        w_illegal = !w_legal;
        w_done    = !w_legal;
        w_next    = w_legal ? S_EXEC : S_FETCH;
      end
      S_EXEC: begin
        w_alu_src_b = w_ori | w_lui | w_mem;
        w_alu_op    = (w_subu | w_beq) ? 3'd1 : w_ori ? 3'd2 : w_lui ? 3'd3 : 3'd0;
        w_pc_we     = (w_beq & i_zero) | w_jal | w_jr;
        w_pc_src    = w_beq ? 2'd1 : w_jal ? 2'd2 : w_jr ? 2'd3 : 2'd0;
        w_reg_we    = w_jal;
        w_reg_dst   = w_jal ? 2'd2 : 2'd0;
        w_wd_sel    = w_jal ? 2'd2 : 2'd0;
        w_done      = w_beq | w_jal | w_jr;
        w_next      = w_mem ? S_MEM : w_alu ? S_WB : S_FETCH;
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_be  = w_sw ? 4'hF : w_sb ? (4'b0001 << i_addr_lo) : 4'h0;
        w_mem_err = w_tmo;
        w_done    = w_tmo | (i_mem_ack & w_store);
        w_next    = w_tmo ? S_FETCH : i_mem_ack ? (w_lw ? S_WB : S_FETCH) : S_MEM;
      end
      S_WB: begin
        w_reg_we  = 1'b1;
        w_reg_dst = (w_addu | w_subu) ? 2'd1 : 2'd0;
        w_wd_sel  = w_lw ? 2'd1 : 2'd0;
        w_done    = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end
  // Strobes are forced low while reset is held so an in-flight access or write dies immediately
  assign o_pc_we      = i_reset_n & w_pc_we;
  assign o_ir_we      = i_reset_n & w_ir_we;
  assign o_reg_we     = i_reset_n & w_reg_we;
  assign o_mem_req    = i_reset_n & w_mem_req;
  assign o_mem_be     = i_reset_n ? w_mem_be : 4'd0;
  assign o_mem_err    = i_reset_n & w_mem_err;
  assign o_illegal    = i_reset_n & w_illegal;
  assign o_instr_done = i_reset_n & w_done;
  assign o_pc_src     = w_pc_src;
  assign o_alu_src_b  = w_alu_src_b;
  assign o_alu_op     = w_alu_op;
  assign o_reg_dst    = w_reg_dst;
  assign o_wd_sel     = w_wd_sel;
  assign o_ext_sign   = (r_state != S_FETCH) && (w_lw | w_store | w_beq);
  assign o_retired    = r_retired;
endmodule
